// File: rtl/reg_port_arbiter_if.sv
// Requester and downstream register-port signals of reg_port_arbiter.
// slave = arbiter side, master = requesters plus register file side.
interface reg_port_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 16,
  parameter int SW = 2
);
  logic [1:0]      req_i;
  logic [1:0]      we_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [2*SW-1:0] strb_i;
  logic [1:0]      ack_o;
  logic            err_o;
  logic [DW-1:0]   rdata_o;
  logic            reg_req;
  logic            reg_we;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [SW-1:0]   reg_strb;
  logic            reg_ack;
  logic [DW-1:0]   reg_rdata;
  logic            reg_err;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, strb_i,
    input  reg_ack, reg_rdata, reg_err,
    output ack_o, err_o, rdata_o,
    output reg_req, reg_we, reg_addr, reg_wdata, reg_strb
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, strb_i,
    output reg_ack, reg_rdata, reg_err,
    input  ack_o, err_o, rdata_o,
    input  reg_req, reg_we, reg_addr, reg_wdata, reg_strb
  );
endinterface

// File: rtl/reg_port_arbiter.sv
// Round-robin share of one register port between ch0 (APB) and
// ch1 (SPI bridge), with address range check and access timeout.
module reg_port_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 16,
  parameter int SW       = 2,
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 16
) (
  input logic               pclk,
  input logic               preset,
  reg_port_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   NREG = (AW+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          r_state, w_state;
  logic            r_last, w_last;
  logic            r_win, w_win;
  logic [TW-1:0]   r_timer, w_timer;
  logic [1:0]      r_ack, w_ack;
  logic            r_err, w_err;
  logic [DW-1:0]   r_rdata, w_rdata;
  logic            r_req, w_req;
  logic            r_we, w_we;
  logic [AW-1:0]   r_addr, w_addr;
  logic [DW-1:0]   r_wdata, w_wdata;
  logic [SW-1:0]   r_strb, w_strb;

  logic            w_pick;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [SW-1:0]   w_sel_strb;

  // With both requesting, the channel not granted last time wins
  assign w_pick = (bus.req_i == 2'b11) ? ~r_last : bus.req_i[1];

  assign w_sel_we    = bus.we_i[w_pick];
  assign w_sel_addr  = w_pick ? bus.addr_i[2*AW-1:AW]
                              : bus.addr_i[AW-1:0];
  assign w_sel_wdata = w_pick ? bus.wdata_i[2*DW-1:DW]
                              : bus.wdata_i[DW-1:0];
  assign w_sel_strb  = w_pick ? bus.strb_i[2*SW-1:SW]
                              : bus.strb_i[SW-1:0];

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_win   = r_win;
    w_timer = r_timer;
    w_ack   = '0;
    w_err   = 1'b0;
    w_rdata = '0;
    w_req   = r_req;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_strb  = r_strb;
    unique case (r_state)
      IDLE: begin
        if (|bus.req_i) begin
          w_win  = w_pick;
          w_last = w_pick;
          if ({1'b0, w_sel_addr} < NREG) begin
            w_state = ACCESS;
            w_req   = 1'b1;
            w_we    = w_sel_we;
            w_addr  = w_sel_addr;
            w_wdata = w_sel_wdata;
            w_strb  = w_sel_we ? w_sel_strb : '0;
            w_timer = '0;
          end else begin
            w_state        = RESP;
            w_ack[w_pick]  = 1'b1;
            w_err          = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (bus.reg_ack || r_timer == TMAX) begin
          w_state      = RESP;
          w_ack[r_win] = 1'b1;
          w_err        = bus.reg_ack ? bus.reg_err : 1'b1;
          w_rdata      = (bus.reg_ack && !bus.reg_err && !r_we)
                         ? bus.reg_rdata : '0;
          w_req        = 1'b0;
          w_we         = 1'b0;
          w_addr       = '0;
          w_wdata      = '0;
          w_strb       = '0;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_timer <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_win   <= w_win;
      r_timer <= w_timer;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_rdata <= w_rdata;
      r_req   <= w_req;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_strb  <= w_strb;
    end
  end

  assign bus.ack_o     = r_ack;
  assign bus.err_o     = r_err;
  assign bus.rdata_o   = r_rdata;
  assign bus.reg_req   = r_req;
  assign bus.reg_we    = r_we;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_strb  = r_strb;
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: vector table, hand sequences for
// alternation and reset, randomized accesses against a grant model.
module tb_reg_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int NR = 4;
  localparam int TO = 16;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  reg_port_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

  reg_port_arbiter #(
    .AW(AW), .DW(DW), .SW(SW), .NUM_REGS(NR), .TIMEOUT(TO)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wt;
    logic [15:0] dn_rdata;
    logic        dn_err;
    logic [1:0]  e_ack;
    logic        e_err;
    logic [15:0] e_rdata;
    int          e_lat;
    int          e_reqs;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_strb;
  } vec_t;

  int   vecs = 0;
  int   miscmp = 0;
  logic m_last;
  vec_t tbl[8];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {bus.ack_o, bus.err_o, bus.rdata_o, bus.reg_req,
             bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.reg_strb},
        64'h0);
  endtask

  task automatic run(input vec_t v, input string nm);
    int cyc;
    int reqs;
    bit done;
    cyc  = 0;
    reqs = 0;
    done = 1'b0;
    bus.req_i   = v.req;
    bus.we_i    = v.we;
    bus.addr_i  = v.addr;
    bus.wdata_i = v.wdata;
    bus.strb_i  = v.strb;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      bus.reg_ack   = 1'b0;
      bus.reg_err   = 1'b0;
      bus.reg_rdata = 16'h0;
      if (bus.ack_o != 2'b00) begin
        done = 1'b1;
        chk({nm, " ack_o"}, bus.ack_o, v.e_ack);
        chk({nm, " err_o"}, bus.err_o, v.e_err);
        chk({nm, " rdata_o"}, bus.rdata_o, v.e_rdata);
        chk({nm, " latency"}, cyc, v.e_lat);
        chk({nm, " reg_req cycles"}, reqs, v.e_reqs);
        bus.req_i = 2'b00;
      end else begin
        chk({nm, " quiet"}, {bus.err_o, bus.rdata_o}, 64'h0);
        if (bus.reg_req) begin
          chk({nm, " downstream"},
              {bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.reg_strb},
              {v.e_we, v.e_addr, v.e_wdata, v.e_strb});
          if (reqs == v.wt) begin
            bus.reg_ack   = 1'b1;
            bus.reg_rdata = v.dn_rdata;
            bus.reg_err   = v.dn_err;
          end
          reqs++;
        end
      end
    end
    if (!done) begin
      vecs++;
      miscmp++;
      $display("FAIL %s: no ack_o within 40 cycles", nm);
    end
    // a late reg_ack after a timeout must not produce anything
    if (v.wt < 0) bus.reg_ack = 1'b1;
    tick();
    chk({nm, " single pulse"}, {bus.ack_o, bus.reg_req}, 64'h0);
    bus.reg_ack = 1'b0;
    bus.req_i   = 2'b00;
    m_last      = v.e_ack[1];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v6;
    preset        = 1'b1;
    bus.req_i     = 2'b00;
    bus.we_i      = 2'b00;
    bus.addr_i    = 8'h0;
    bus.wdata_i   = 32'h0;
    bus.strb_i    = 4'h0;
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = 16'h0;
    bus.reg_err   = 1'b0;
    tick();
    tick();
    chk_zero("reset state");
    preset = 1'b0;
    m_last = 1'b1;
    tick();

    tbl[0] = '{2'b01, 2'b01, 8'h01, 32'h0000_4ead, 4'b0010, 1,
               16'h1234, 1'b0, 2'b01, 1'b0, 16'h0, 3, 2,
               1'b1, 4'h1, 16'h4ead, 2'b10};
    tbl[1] = '{2'b10, 2'b00, 8'h30, 32'h5555_0000, 4'b1100, 3,
               16'hfeed, 1'b0, 2'b10, 1'b0, 16'hfeed, 5, 4,
               1'b0, 4'h3, 16'h5555, 2'b00};
    tbl[2] = '{2'b01, 2'b00, 8'h05, 32'h0, 4'b0000, 0,
               16'hdead, 1'b0, 2'b01, 1'b1, 16'h0, 1, 0,
               1'b0, 4'h0, 16'h0, 2'b00};
    tbl[3] = '{2'b10, 2'b10, 8'h20, 32'hbeef_0000, 4'b0100, -1,
               16'h7777, 1'b0, 2'b10, 1'b1, 16'h0, 17, 16,
               1'b1, 4'h2, 16'hbeef, 2'b01};
    tbl[4] = '{2'b01, 2'b00, 8'h02, 32'h0000_1111, 4'b0011, 0,
               16'habcd, 1'b1, 2'b01, 1'b1, 16'h0, 2, 1,
               1'b0, 4'h2, 16'h1111, 2'b00};
    tbl[5] = '{2'b10, 2'b10, 8'h00, 32'h0f0f_0000, 4'b1100, 15,
               16'h9999, 1'b0, 2'b10, 1'b0, 16'h0, 17, 16,
               1'b1, 4'h0, 16'h0f0f, 2'b11};
    tbl[6] = '{2'b01, 2'b00, 8'h03, 32'h0, 4'b0000, 0,
               16'h8001, 1'b0, 2'b01, 1'b0, 16'h8001, 2, 1,
               1'b0, 4'h3, 16'h0, 2'b00};
    tbl[7] = '{2'b10, 2'b10, 8'h40, 32'h1234_0000, 4'b1100, 0,
               16'h0, 1'b0, 2'b10, 1'b1, 16'h0, 1, 0,
               1'b0, 4'h0, 16'h0, 2'b00};
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // reset in the middle of an access
    bus.req_i   = 2'b01;
    bus.we_i    = 2'b01;
    bus.addr_i  = 8'h01;
    bus.wdata_i = 32'h0000_aaaa;
    bus.strb_i  = 4'b0011;
    tick();
    tick();
    chk("T6 in access", bus.reg_req, 64'h1);
    preset = 1'b1;
    tick();
    chk_zero("T6 after reset");
    preset    = 1'b0;
    bus.req_i = 2'b00;
    m_last    = 1'b1;
    tick();
    chk("T6 no ack", bus.ack_o, 64'h0);
    v6 = '{2'b10, 2'b00, 8'h10, 32'h0, 4'b0000, 0,
           16'h0bad, 1'b0, 2'b10, 1'b0, 16'h0bad, 2, 1,
           1'b0, 4'h1, 16'h0, 2'b00};
    run(v6, "T6 ch1");

    // both held from reset: ch0 first, then strict alternation
    preset = 1'b1;
    tick();
    preset = 1'b0;
    m_last = 1'b1;
    bus.we_i   = 2'b00;
    bus.addr_i = 8'h20;
    bus.req_i  = 2'b11;
    begin
      int   got;
      int   cyc;
      logic exp_w;
      got   = 0;
      cyc   = 0;
      exp_w = ~m_last;
      while (got < 4 && cyc < 60) begin
        tick();
        cyc++;
        bus.reg_ack = 1'b0;
        if (bus.ack_o != 2'b00) begin
          chk("T3 order", bus.ack_o, exp_w ? 2'b10 : 2'b01);
          m_last = exp_w;
          exp_w  = ~exp_w;
          got++;
        end else if (bus.reg_req) begin
          chk("T3 addr", bus.reg_addr, exp_w ? 4'h2 : 4'h0);
          bus.reg_ack = 1'b1;
        end
      end
      if (got < 4) begin
        vecs++;
        miscmp++;
        $display("FAIL T3: %0d acks seen, 4 required", got);
      end
    end
    bus.req_i = 2'b00;
    tick();
    tick();

    for (int i = 0; i < 300; i++) begin
      vec_t       v;
      logic       w;
      logic [3:0] a;
      logic       oor;
      logic       to;
      v.req      = 2'($urandom_range(1, 3));
      v.we       = 2'($urandom);
      v.addr     = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      v.wdata    = $urandom;
      v.strb     = 4'($urandom);
      if ($urandom_range(0, 9) == 0) v.wt = -1;
      else v.wt = int'($urandom_range(0, 4));
      v.dn_rdata = 16'($urandom);
      v.dn_err   = ($urandom_range(0, 7) == 0);
      w          = (v.req == 2'b11) ? ~m_last : v.req[1];
      a          = w ? v.addr[7:4] : v.addr[3:0];
      oor        = (int'(a) >= NR);
      to         = !oor && v.wt < 0;
      v.e_ack    = w ? 2'b10 : 2'b01;
      v.e_err    = oor || to || v.dn_err;
      v.e_we     = v.we[w];
      v.e_addr   = a;
      v.e_wdata  = w ? v.wdata[31:16] : v.wdata[15:0];
      v.e_strb   = v.e_we ? (w ? v.strb[3:2] : v.strb[1:0]) : 2'b00;
      v.e_rdata  = (!v.e_we && !v.e_err) ? v.dn_rdata : 16'h0;
      v.e_lat    = oor ? 1 : (to ? TO + 1 : v.wt + 2);
      v.e_reqs   = oor ? 0 : (to ? TO : v.wt + 1);
      run(v, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
